adder_sum_accumulator: RTL and testbench



---
 rtl/adder_pkg.sv | 14 +
 rtl/adder_sum_accumulator_sample_counter.sv | 38 +++
 rtl/adder_sum_accumulator.sv | 117 +++++++++++
 tb/tb_adder_sum_accumulator.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and constants for the adder result path.
// Used by the sum accumulator and its sample counter.
package adder_pkg;

  localparam int SUM_W   = 5;
  localparam int MAX_SUM = 30;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/adder_sum_accumulator_sample_counter.sv
// Counts accepted samples within a frame.
// Flags the final sample of the frame.
module sample_counter #(
  parameter int NUM_SAMPLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic last
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // With NUM_SAMPLES==1 this is true in IDLE, so the first accept closes the frame.
  assign last = (cnt_q == CNT_W'(NUM_SAMPLES - 1));

endmodule

// File: rtl/adder_sum_accumulator.sv
// Accumulates NUM_SAMPLES adder sums into a frame total behind valid/ready handshakes.
// Define ACC_SAT_EN to saturate the total on overflow instead of wrapping.
module adder_sum_accumulator
  import adder_pkg::*;
#(
  parameter int NUM_SAMPLES = 8,
  parameter int ACC_W       = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             last;
  logic             frame_done;
  logic [ACC_W:0]   sum_ext;
  logic             carry;

  assign in_ready   = (state_q != HOLD);
  assign accept     = in_valid & in_ready;
  assign frame_done = (state_q == HOLD) & out_ready;

  assign sum_ext = {1'b0, acc_q} + (ACC_W + 1)'(in_sum);
  assign carry   = sum_ext[ACC_W];

  sample_counter #(
    .NUM_SAMPLES (NUM_SAMPLES),
    .CNT_W       (CNT_W)
  ) u_sample_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr | frame_done),
    .inc  (accept & ~clr),
    .last (last)
  );

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            acc_d   = ACC_W'(in_sum);
            ovf_d   = 1'b0;
            state_d = last ? HOLD : ACC;
          end
        end
        ACC: begin
          if (accept) begin
`ifdef ACC_SAT_EN
            // Once saturated, any further add carries again (or adds zero), so it sticks.
            acc_d = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
            acc_d = sum_ext[ACC_W-1:0];
`endif
            ovf_d = ovf_q | carry;
            if (last) begin
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = IDLE;
            acc_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = '0;
          ovf_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs come only from flops; the HOLD gate keeps them at zero elsewhere.
  assign out_valid = (state_q == HOLD);
  assign out_sum   = out_valid ? acc_q : '0;
  assign out_ovf   = out_valid & ovf_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Self-checking bench: three instances (8, 16 and 3 samples per frame), directed
// scenarios followed by random frames compared against a frame-total model.
module tb_adder_sum_accumulator;
  import adder_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       clr       [3];
  logic       in_valid  [3];
  logic [4:0] in_sum    [3];
  logic       out_ready [3];
  logic       in_ready  [3];
  logic       out_valid [3];
  logic [7:0] out_sum   [3];
  logic       out_ovf   [3];
  logic       busy      [3];

  int n_checks = 0;
  int n_fail   = 0;
  int ns [3] = '{8, 16, 3};

  adder_sum_accumulator #(.NUM_SAMPLES(8), .ACC_W(8), .CNT_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .clr(clr[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_sum(in_sum[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_sum(out_sum[0]), .out_ovf(out_ovf[0]), .busy(busy[0]));

  adder_sum_accumulator #(.NUM_SAMPLES(16), .ACC_W(8), .CNT_W(8)) u_dut16 (
    .clk(clk), .rst(rst), .clr(clr[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_sum(in_sum[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_sum(out_sum[1]), .out_ovf(out_ovf[1]), .busy(busy[1]));

  adder_sum_accumulator #(.NUM_SAMPLES(3), .ACC_W(8), .CNT_W(8)) u_dut3 (
    .clk(clk), .rst(rst), .clr(clr[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_sum(in_sum[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_sum(out_sum[2]), .out_ovf(out_ovf[2]), .busy(busy[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Frame total as seen at the output, from the plain arithmetic sum of all samples.
  function automatic int model_sum(input int total);
`ifdef ACC_SAT_EN
    return (total > 255) ? 255 : total;
`else
    return total % 256;
`endif
  endfunction

  task automatic send(input int d, input int v);
    logic [31:0] vv;
    vv = v;
    check($sformatf("in_ready_before_send[%0d]", d), in_ready[d], 1);
    in_valid[d] = 1'b1;
    in_sum[d]   = vv[4:0];
    step();
    in_valid[d] = 1'b0;
  endtask

  task automatic check_frame(input int d, input int total);
    check($sformatf("out_valid[%0d]", d), out_valid[d], 1);
    check($sformatf("out_sum[%0d]", d), out_sum[d], model_sum(total));
    check($sformatf("out_ovf[%0d]", d), out_ovf[d], (total > 255) ? 1 : 0);
    check($sformatf("in_ready_hold[%0d]", d), in_ready[d], 0);
    check($sformatf("busy_hold[%0d]", d), busy[d], 1);
  endtask

  task automatic release_frame(input int d);
    out_ready[d] = 1'b1;
    step();
    out_ready[d] = 1'b0;
    check($sformatf("out_valid_after_release[%0d]", d), out_valid[d], 0);
    check($sformatf("in_ready_after_release[%0d]", d), in_ready[d], 1);
    check($sformatf("out_sum_after_release[%0d]", d), out_sum[d], 0);
    check($sformatf("busy_after_release[%0d]", d), busy[d], 0);
  endtask

  initial begin
    int total;
    int v;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clr[i] = 1'b0; in_valid[i] = 1'b0; in_sum[i] = '0; out_ready[i] = 1'b0;
    end
    #12;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_in_ready[%0d]", i), in_ready[i], 1);
      check($sformatf("rst_out_valid[%0d]", i), out_valid[i], 0);
      check($sformatf("rst_out_sum[%0d]", i), out_sum[i], 0);
      check($sformatf("rst_out_ovf[%0d]", i), out_ovf[i], 0);
      check($sformatf("rst_busy[%0d]", i), busy[i], 0);
    end
    @(negedge clk);
    rst = 1'b0;
    step();

    // 8 x 30 with default frame length; out_valid must appear right after the 8th accept.
    for (int i = 0; i < 7; i++) send(0, 30);
    check("out_valid_before_last", out_valid[0], 0);
    check("busy_in_acc", busy[0], 1);
    send(0, 30);
    check_frame(0, 240);

    // HOLD with sink stalled while a sample is offered: must be ignored.
    in_valid[0] = 1'b1;
    in_sum[0]   = 5'd7;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_in_ready", in_ready[0], 0);
      check("hold_out_sum", out_sum[0], 240);
      check("hold_out_valid", out_valid[0], 1);
    end
    out_ready[0] = 1'b1;
    step();
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b0;
    check("hold_exit_in_ready", in_ready[0], 1);
    check("hold_exit_out_valid", out_valid[0], 0);
    check("hold_exit_busy", busy[0], 0);

    // 16 x 30 overflows 8 bits.
    for (int i = 0; i < 16; i++) send(1, 30);
    check_frame(1, 480);
    release_frame(1);

    // 1,2,3 separated by bubbles on the 3-sample instance.
    send(2, 1); step(); step();
    send(2, 2); step(); step();
    check("bubble_no_early_valid", out_valid[2], 0);
    send(2, 3);
    check_frame(2, 6);
    release_frame(2);

    // Asynchronous reset mid-frame, then a fresh frame of ones.
    for (int i = 0; i < 3; i++) send(0, 5);
    rst = 1'b1;
    #1;
    check("async_rst_busy", busy[0], 0);
    check("async_rst_in_ready", in_ready[0], 1);
    check("async_rst_out_valid", out_valid[0], 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    for (int i = 0; i < 8; i++) send(0, 1);
    check_frame(0, 8);
    release_frame(0);

    // clr in ACC with a sample offered: sample dropped, fresh frame restarts.
    for (int i = 0; i < 4; i++) send(0, 5);
    clr[0] = 1'b1; in_valid[0] = 1'b1; in_sum[0] = 5'd9;
    step();
    clr[0] = 1'b0; in_valid[0] = 1'b0;
    check("clr_busy", busy[0], 0);
    check("clr_out_valid", out_valid[0], 0);
    for (int i = 0; i < 8; i++) send(0, 2);
    check_frame(0, 16);
    release_frame(0);

    // Random frames on every instance with random bubbles and sink stalls.
    for (int d = 0; d < 3; d++) begin
      for (int f = 0; f < 4; f++) begin
        total = 0;
        for (int i = 0; i < ns[d]; i++) begin
          repeat ($urandom_range(0, 2)) step();
          v = $urandom_range(0, MAX_SUM);
          send(d, v);
          total += v;
        end
        check_frame(d, total);
        for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
          step();
          check($sformatf("rand_hold_sum[%0d]", d), out_sum[d], model_sum(total));
        end
        release_frame(d);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
